neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Downstream stage of the per-neuron weight multiplier. It sums a stream of signed fixed-point products, one per input, for exactly `num_weights` valid products. It then adds the neuron bias, rescales to `data_bits`, saturates, and presents one neuron pre-activation value with a single-cycle valid pulse. Its output feeds the activation stage, and its `out_valid` also serves as the neuron-done strobe for the weight memory controller.

## Interface
Parameters:
- `data_bits`, 16: width of the neuron input, the weight, and `neuron_out`; two's complement.
- `frac_bits`, 8: fractional bits of inputs, weights, bias and `neuron_out`. Products therefore carry 2·`frac_bits`.
- `num_weights`, 784: products per neuron vector; must be ≥ 1.
- `bias_value`, 0: signed `data_bits` bias in the same Q format as `neuron_out`.

Ports:
- `clk` input 1: sole clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `mul_in` input 2·`data_bits`: signed product; the caller aligns it with `mul_valid`.
- `mul_valid` input 1: `mul_in` holds a valid product this cycle.
- `clear` input 1: synchronously abandons the partial vector.
- `neuron_out` output `data_bits`: saturated result; holds its value between pulses.
- `out_valid` output 1: one-cycle pulse when `neuron_out` is updated.
- `sat_flag` output 1: qualified by `out_valid`; 1 if the result was clipped.

## Operation
- Accumulator width is `acc_bits` = 2·`data_bits` + clog2(`num_weights`) + 1. Intermediate overflow is impossible, so there is no per-step saturation.
- Input counter `cnt` runs 0..`num_weights`−1 and advances only on `mul_valid`. Cycles without `mul_valid` change nothing.
- On a non-last valid product: `acc` ← `acc` + sign-extended `mul_in`; `cnt` ← `cnt`+1.
- On the last valid product (`cnt` = `num_weights`−1):
  - `sum_r` ← `acc` + `mul_in` + (sign-extended `bias_value` <<< `frac_bits`).
  - `pend` ← 1.
  - `acc` ← 0 and `cnt` ← 0 in the same cycle, so the next vector may start on the very next cycle.
- Finalize stage, when `pend` = 1:
  - `scaled` = `sum_r` >>> `frac_bits` (arithmetic shift, truncation toward −∞).
  - If `scaled` > 2^(`data_bits`−1)−1, the output is the maximum positive value. If `scaled` < −2^(`data_bits`−1), the output is the maximum negative value. Otherwise it is the low `data_bits` of `scaled`.
  - Register the result into `neuron_out`; pulse `out_valid`; set `sat_flag` to 1 if clipped, else 0.
  - `pend` ← 0.
- `clear`:
  - Sets `acc` ← 0 and `cnt` ← 0.
  - A `mul_valid` in the same cycle is discarded.
  - A `pend` already set still completes normally.
- `reset`: `acc`, `cnt`, `sum_r` and `pend` go to 0. `reset` wins over `clear` and `mul_valid` in the same cycle.
- `num_weights` = 1: every valid product is the last one.

## Timing
- Reset values: `neuron_out` = 0, `out_valid` = 0, `sat_flag` = 0.
- Latency: last product accepted at edge T gives `out_valid` high during the cycle after edge T+1. That is 2 cycles from the product being presented to the result being visible.
- Throughput: one product per cycle sustained, no stall and no backpressure. Back-to-back vectors give `out_valid` pulses exactly `num_weights` cycles apart.
- `out_valid` is never high for two consecutive cycles unless `num_weights` = 1 and `mul_valid` is continuous.
- Reset asserted while `pend` = 1 suppresses the pending `out_valid`.

## Structure
- Shared package (`definitions.sv`):
  - function `acc_width(data_bits, num_weights)`;
  - Q-format max/min constant helpers;
  - the `frac_bits` default.
- One sub-module: `fixed_point_saturate`. It is purely combinational; parameterized by input width, output width and `frac_bits`; outputs are the value and a clipped flag.
- The counter, accumulator and finalize register live in `neuron_accumulator`.

## Test plan
The bench uses `data_bits`=16, `frac_bits`=8, `num_weights`=4, `bias_value`=0 unless stated.
- Four consecutive products of 32'h0001_0000 (1.0·1.0) → `neuron_out` = 16'h0400 two cycles after the 4th, `out_valid` one cycle, `sat_flag` = 0.
- `bias_value` = 16'hFF00 (−1.0), same four products → `neuron_out` = 16'h0300.
- Saturation:
  - Four products of 32'h3FFF_0001 → 16'h7FFF, `sat_flag` = 1.
  - Four products of 32'hC000_8000 → 16'h8000, `sat_flag` = 1.
- Eight back-to-back products of 32'h0000_0100, with `mul_valid` gaps of 0–3 random cycles inserted → two pulses, each `neuron_out` = 16'h0004; pulses occur only after the 4th and 8th valid products.
- Two products, then `clear` asserted together with a third product, then four products of 32'h0001_0000 → single pulse with 16'h0400.
- `reset` asserted one cycle after the 4th product (while `pend` = 1) → no `out_valid`; all outputs 0; the next full vector produces the correct result.

Source files
------------

// File: rtl/neuron_accumulator_pkg.sv
// Shared helpers for the neuron accumulator slice: accumulator sizing,
// Q-format range limits and the default fractional width.
package neuron_accumulator_pkg;

  localparam int FRAC_BITS_DEFAULT = 8;

  function automatic int acc_width(input int data_bits, input int num_weights);
    return 2 * data_bits + $clog2(num_weights) + 1;
  endfunction

  function automatic longint q_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint q_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_accumulator_saturate.sv
// Combinational rescale-and-clip: drops frac_bits fractional bits (toward
// minus infinity) and saturates to a signed out_w result.
module fixed_point_saturate
  import neuron_accumulator_pkg::*;
#(
  parameter int in_w      = 43,
  parameter int out_w     = 16,
  parameter int frac_bits = FRAC_BITS_DEFAULT
) (
  input  logic [in_w-1:0]  din,
  output logic [out_w-1:0] dout,
  output logic             clipped
);

  localparam logic signed [in_w-1:0] MAX_V = in_w'(q_max(out_w));
  localparam logic signed [in_w-1:0] MIN_V = in_w'(q_min(out_w));

  // Returns {clipped, value}.
  function automatic logic [out_w:0] sat_fn(input logic signed [in_w-1:0] v);
    logic signed [in_w-1:0] s;
    s = v >>> frac_bits;
    if (s > MAX_V)      return {1'b1, MAX_V[out_w-1:0]};
    else if (s < MIN_V) return {1'b1, MIN_V[out_w-1:0]};
    else                return {1'b0, s[out_w-1:0]};
  endfunction

  assign {clipped, dout} = sat_fn($signed(din));

endmodule

// File: rtl/neuron_accumulator.sv
// Sums num_weights signed products, adds the bias, rescales and saturates,
// emitting one neuron pre-activation per vector with a one-cycle valid.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int                            data_bits   = 16,
  parameter int                            frac_bits   = FRAC_BITS_DEFAULT,
  parameter int                            num_weights = 784,
  parameter logic signed [data_bits-1:0]   bias_value  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*data_bits-1:0] mul_in,
  input  logic                   mul_valid,
  input  logic                   clear,
  output logic [data_bits-1:0]   neuron_out,
  output logic                   out_valid,
  output logic                   sat_flag
);

  localparam int acc_bits = acc_width(data_bits, num_weights);
  localparam int cnt_w    = (num_weights > 1) ? $clog2(num_weights) : 1;
  localparam logic signed [acc_bits-1:0] BIAS_SH = acc_bits'(bias_value) <<< frac_bits;
  localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(num_weights - 1);

  logic signed [acc_bits-1:0] mul_ext;
  logic signed [acc_bits-1:0] acc_p0;
  logic [cnt_w-1:0]           cnt_p0;
  logic signed [acc_bits-1:0] sum_p1;
  logic                       vld_p1;
  logic [data_bits-1:0]       sat_val;
  logic                       sat_clip;

  assign mul_ext = acc_bits'($signed(mul_in));

  // Stage p0 -> p1: accumulate; the last product closes the vector into sum_p1
  // and restarts the accumulator so the next vector can begin immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (clear) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (mul_valid) begin
        if (cnt_p0 == LAST_CNT) begin
          sum_p1 <= acc_p0 + mul_ext + BIAS_SH;
          vld_p1 <= 1'b1;
          acc_p0 <= '0;
          cnt_p0 <= '0;
        end else begin
          acc_p0 <= acc_p0 + mul_ext;
          cnt_p0 <= cnt_p0 + cnt_w'(1);
        end
      end
    end
  end

  fixed_point_saturate #(
    .in_w      (acc_bits),
    .out_w     (data_bits),
    .frac_bits (frac_bits)
  ) u_sat (
    .din     (sum_p1),
    .dout    (sat_val),
    .clipped (sat_clip)
  );

  // Stage p1 -> p2: register the saturated result; neuron_out holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      neuron_out <= '0;
      out_valid  <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        neuron_out <= sat_val;
        sat_flag   <= sat_clip;
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench: two DUTs (bias 0 and bias -1.0) share one stimulus
// stream and are compared every cycle against a vector-level reference model.
module tb_neuron_accumulator;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mul_in = '0;
  logic        mul_valid = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] nout_a, nout_b;
  logic        ov_a, ov_b, sf_a, sf_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_accumulator #(
    .data_bits(16), .frac_bits(8), .num_weights(NW), .bias_value(16'h0000)
  ) dut_a (
    .clk(clk), .reset(reset), .mul_in(mul_in), .mul_valid(mul_valid),
    .clear(clear), .neuron_out(nout_a), .out_valid(ov_a), .sat_flag(sf_a)
  );

  neuron_accumulator #(
    .data_bits(16), .frac_bits(8), .num_weights(NW), .bias_value(16'hFF00)
  ) dut_b (
    .clk(clk), .reset(reset), .mul_in(mul_in), .mul_valid(mul_valid),
    .clear(clear), .neuron_out(nout_b), .out_valid(ov_b), .sat_flag(sf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result of one completed vector from its plain integer sum.
  function automatic logic [16:0] expect_result(input longint total, input int bias);
    longint s;
    s = (total + longint'(bias) * 256) >>> 8;
    if (s > 32767)       return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, s[15:0]};
  endfunction

  typedef struct {
    int          due;
    logic [15:0] val[2];
    logic        sat[2];
  } result_t;

  int          bias_m[2] = '{0, -256};
  int          cyc = 0;
  int          n_in = 0;
  longint      sum_m = 0;
  result_t     pending[$];
  logic        exp_v[2] = '{1'b0, 1'b0};
  logic [15:0] exp_out[2] = '{16'h0, 16'h0};
  logic        exp_s[2] = '{1'b0, 1'b0};
  logic        started = 1'b0;

  always @(posedge clk) begin
    cyc++;
    started <= 1'b1;
    if (reset) begin
      pending.delete();
      n_in = 0;
      sum_m = 0;
      for (int k = 0; k < 2; k++) begin
        exp_v[k] = 1'b0; exp_out[k] = '0; exp_s[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) exp_v[k] = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
        result_t r;
        r = pending.pop_front();
        for (int k = 0; k < 2; k++) begin
          exp_v[k] = 1'b1; exp_out[k] = r.val[k]; exp_s[k] = r.sat[k];
        end
      end
      if (clear) begin
        n_in = 0;
        sum_m = 0;
      end else if (mul_valid) begin
        sum_m += longint'($signed(mul_in));
        n_in++;
        if (n_in == NW) begin
          result_t r;
          logic [16:0] e;
          r.due = cyc + 1;
          for (int k = 0; k < 2; k++) begin
            e = expect_result(sum_m, bias_m[k]);
            r.val[k] = e[15:0];
            r.sat[k] = e[16];
          end
          pending.push_back(r);
          n_in = 0;
          sum_m = 0;
        end
      end
    end
  end

  int          pulses_a = 0;
  logic [15:0] last_a = '0;
  logic        last_sat_a = 1'b0;
  logic [15:0] last_b = '0;

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid_a", {31'b0, ov_a}, {31'b0, exp_v[0]});
      chk("out_valid_b", {31'b0, ov_b}, {31'b0, exp_v[1]});
      chk("neuron_out_a", {16'b0, nout_a}, {16'b0, exp_out[0]});
      chk("neuron_out_b", {16'b0, nout_b}, {16'b0, exp_out[1]});
      if (exp_v[0]) chk("sat_flag_a", {31'b0, sf_a}, {31'b0, exp_s[0]});
      if (exp_v[1]) chk("sat_flag_b", {31'b0, sf_b}, {31'b0, exp_s[1]});
      if (ov_a) begin
        pulses_a++;
        last_a = nout_a;
        last_sat_a = sf_a;
      end
      if (ov_b) last_b = nout_b;
    end
  end

  task automatic step(input logic [31:0] m, input logic v, input logic c);
    mul_in = m; mul_valid = v; clear = c;
    @(negedge clk);
    mul_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step($urandom, 1'b0, 1'b0);
  endtask

  task automatic vec4(input logic [31:0] m);
    for (int i = 0; i < 4; i++) step(m, 1'b1, 1'b0);
  endtask

  int p0;

  initial begin
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", {16'b0, nout_a}, 32'h0);
    chk("reset_valid", {31'b0, ov_a}, 32'h0);
    chk("reset_sat", {31'b0, sf_a}, 32'h0);
    reset = 1'b0;
    idle(2);

    // 1.0 * 1.0 four times; result visible two edges after the last product.
    p0 = pulses_a;
    vec4(32'h0001_0000);
    chk("lat_not_yet", {31'b0, ov_a}, 32'h0);
    idle(1);
    chk("lat_valid", {31'b0, ov_a}, 32'h1);
    chk("unity_a", {16'b0, nout_a}, 32'h0400);
    chk("unity_b", {16'b0, nout_b}, 32'h0300);
    chk("unity_sat", {31'b0, sf_a}, 32'h0);
    idle(1);
    chk("pulse_one_cycle", {31'b0, ov_a}, 32'h0);
    chk("unity_hold", {16'b0, nout_a}, 32'h0400);

    vec4(32'h3FFF_0001);
    idle(3);
    chk("sat_pos", {16'b0, last_a}, 32'h7FFF);
    chk("sat_pos_flag", {31'b0, last_sat_a}, 32'h1);

    vec4(32'hC000_8000);
    idle(3);
    chk("sat_neg", {16'b0, last_a}, 32'h8000);
    chk("sat_neg_flag", {31'b0, last_sat_a}, 32'h1);
    chk("sat_neg_b", {16'b0, last_b}, 32'h8000);

    // Eight small products with random gaps: exactly two pulses.
    p0 = pulses_a;
    for (int i = 0; i < 8; i++) begin
      step(32'h0000_0100, 1'b1, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(3);
    chk("gap_pulses", pulses_a - p0, 2);
    chk("gap_value", {16'b0, last_a}, 32'h0004);
    chk("gap_value_b", {16'b0, last_b}, 32'hFF04);

    // Clear with a simultaneous product discards the partial vector.
    p0 = pulses_a;
    step(32'h0001_0000, 1'b1, 1'b0);
    step(32'h0001_0000, 1'b1, 1'b0);
    step(32'h0001_0000, 1'b1, 1'b1);
    vec4(32'h0001_0000);
    idle(3);
    chk("clear_pulses", pulses_a - p0, 1);
    chk("clear_value", {16'b0, last_a}, 32'h0400);

    // Reset while a result is pending suppresses it.
    p0 = pulses_a;
    vec4(32'h0002_0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_pend_valid", {31'b0, ov_a}, 32'h0);
    chk("rst_pend_out", {16'b0, nout_a}, 32'h0);
    chk("rst_pend_sat", {31'b0, sf_a}, 32'h0);
    idle(3);
    chk("rst_pend_pulses", pulses_a - p0, 0);
    vec4(32'h0001_0000);
    idle(3);
    chk("rst_after_value", {16'b0, last_a}, 32'h0400);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] m;
      m = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(16'($urandom)) * 300);
      if ($urandom_range(0, 150) == 0) begin
        reset = 1'b1;
        step(m, 1'($urandom_range(0, 1)), 1'b0);
        reset = 1'b0;
      end else begin
        step(m, $urandom_range(0, 3) != 0, $urandom_range(0, 25) == 0);
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
